micro_sequencer: RTL and testbench

Microprogram sequencer for the micro-datapath: holds the control-store address (microPC) and the processor status register (PSR). It advances the microPC each cycle using the 2-bit branch type produced by the branch logic. It also stalls the datapath around memory accesses with a request/acknowledge handshake and a timeout, and supplies the registered PSR flags that the branch logic evaluates.

---
 rtl/micro_sequencer.sv | 118 +++++++++++
 tb/tb_micro_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: microPC/PSR registers, next-address selection and
// the memory request/acknowledge stall with timeout-to-halt.
module micro_sequencer #(
    parameter int unsigned MICRO_SEQUENCER_ADDR    = 11,
    parameter int unsigned MICRO_SEQUENCER_PSR     = 4,
    parameter int unsigned MICRO_SEQUENCER_TIPO    = 2,
    parameter int unsigned MICRO_SEQUENCER_TIMEOUT = 16
) (
    input  logic                               MICRO_SEQUENCER_CLOCK_50,
    input  logic                               MICRO_SEQUENCER_ResetInLow_In,
    input  logic [MICRO_SEQUENCER_TIPO-1:0]    MICRO_SEQUENCER_Tipo_InBus,
    input  logic [MICRO_SEQUENCER_ADDR-1:0]    MICRO_SEQUENCER_JumpAddr_InBus,
    input  logic [7:0]                         MICRO_SEQUENCER_IROp_InBus,
    input  logic                               MICRO_SEQUENCER_MemAccess_In,
    input  logic                               MICRO_SEQUENCER_MemAck_In,
    input  logic                               MICRO_SEQUENCER_Halt_In,
    input  logic                               MICRO_SEQUENCER_PsrLoad_In,
    input  logic [MICRO_SEQUENCER_PSR-1:0]     MICRO_SEQUENCER_AluFlags_InBus,
    output logic [MICRO_SEQUENCER_ADDR-1:0]    MICRO_SEQUENCER_CsAddr_OutBus,
    output logic [MICRO_SEQUENCER_PSR-1:0]     MICRO_SEQUENCER_Psr_OutBus,
    output logic                               MICRO_SEQUENCER_MemReq_Out,
    output logic                               MICRO_SEQUENCER_Stall_Out,
    output logic                               MICRO_SEQUENCER_Halted_Out,
    output logic                               MICRO_SEQUENCER_Error_Out
);

    localparam int unsigned CNT_W = (MICRO_SEQUENCER_TIMEOUT > 2) ? $clog2(MICRO_SEQUENCER_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MICRO_SEQUENCER_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MEMWAIT = 2'b01,
        HALT    = 2'b10,
        BAD     = 2'b11
    } state_t;

    state_t                          state;
    logic [CNT_W-1:0]                cnt;
    logic [MICRO_SEQUENCER_ADDR-1:0] upc;
    logic [MICRO_SEQUENCER_ADDR-1:0] next_addr;
    logic [MICRO_SEQUENCER_PSR-1:0]  psr;
    logic                            mem_req;
    logic                            err;
    logic                            stall;

    // Decode target: 1, op[1:0], op3[5:0], 00 -- narrow/wide address widths are padded/truncated.
    logic [10:0] decode_addr;
    assign decode_addr = {1'b1, MICRO_SEQUENCER_IROp_InBus, 2'b00};

    always_comb begin
        next_addr = upc + 1'b1;
        case (MICRO_SEQUENCER_Tipo_InBus[1:0])
            2'b01:   next_addr = MICRO_SEQUENCER_JumpAddr_InBus;
            2'b10:   next_addr = MICRO_SEQUENCER_ADDR'(decode_addr);
            default: next_addr = upc + 1'b1;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            RUN:     stall = MICRO_SEQUENCER_Halt_In | MICRO_SEQUENCER_MemAccess_In;
            MEMWAIT: stall = ~MICRO_SEQUENCER_MemAck_In;
            default: stall = 1'b1;
        endcase
    end

    always_ff @(posedge MICRO_SEQUENCER_CLOCK_50 or negedge MICRO_SEQUENCER_ResetInLow_In) begin
        if (!MICRO_SEQUENCER_ResetInLow_In) begin
            state   <= RUN;
            cnt     <= '0;
            upc     <= '0;
            psr     <= '0;
            mem_req <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (MICRO_SEQUENCER_PsrLoad_In && !stall)
                psr <= MICRO_SEQUENCER_AluFlags_InBus;
            case (state)
                RUN: begin
                    if (MICRO_SEQUENCER_Halt_In) begin
                        state <= HALT;
                    end else if (MICRO_SEQUENCER_MemAccess_In) begin
                        state   <= MEMWAIT;
                        mem_req <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        upc <= next_addr;
                    end
                end
                MEMWAIT: begin
                    // Ack is tested first so it wins over a coincident timeout.
                    if (MICRO_SEQUENCER_MemAck_In) begin
                        upc     <= next_addr;
                        mem_req <= 1'b0;
                        state   <= RUN;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err     <= 1'b1;
                        state   <= HALT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HALT: ;
                default: state <= HALT;
            endcase
        end
    end

    assign MICRO_SEQUENCER_CsAddr_OutBus = upc;
    assign MICRO_SEQUENCER_Psr_OutBus    = psr;
    assign MICRO_SEQUENCER_MemReq_Out    = mem_req;
    assign MICRO_SEQUENCER_Stall_Out     = stall;
    assign MICRO_SEQUENCER_Halted_Out    = (state == HALT);
    assign MICRO_SEQUENCER_Error_Out     = err;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with hand-computed expectations.
module tb_micro_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  tipo = '0;
    logic [10:0] jump_addr = '0;
    logic [7:0]  ir_op = '0;
    logic        mem_access = 1'b0;
    logic        mem_ack = 1'b0;
    logic        halt = 1'b0;
    logic        psr_load = 1'b0;
    logic [3:0]  alu_flags = '0;
    logic [10:0] cs_addr;
    logic [3:0]  psr;
    logic        mem_req;
    logic        stall;
    logic        halted;
    logic        err;

    int unsigned total = 0;
    int unsigned bad = 0;

    micro_sequencer #(
        .MICRO_SEQUENCER_ADDR   (11),
        .MICRO_SEQUENCER_PSR    (4),
        .MICRO_SEQUENCER_TIPO   (2),
        .MICRO_SEQUENCER_TIMEOUT(16)
    ) dut (
        .MICRO_SEQUENCER_CLOCK_50      (clk),
        .MICRO_SEQUENCER_ResetInLow_In (rst_n),
        .MICRO_SEQUENCER_Tipo_InBus    (tipo),
        .MICRO_SEQUENCER_JumpAddr_InBus(jump_addr),
        .MICRO_SEQUENCER_IROp_InBus    (ir_op),
        .MICRO_SEQUENCER_MemAccess_In  (mem_access),
        .MICRO_SEQUENCER_MemAck_In     (mem_ack),
        .MICRO_SEQUENCER_Halt_In       (halt),
        .MICRO_SEQUENCER_PsrLoad_In    (psr_load),
        .MICRO_SEQUENCER_AluFlags_InBus(alu_flags),
        .MICRO_SEQUENCER_CsAddr_OutBus (cs_addr),
        .MICRO_SEQUENCER_Psr_OutBus    (psr),
        .MICRO_SEQUENCER_MemReq_Out    (mem_req),
        .MICRO_SEQUENCER_Stall_Out     (stall),
        .MICRO_SEQUENCER_Halted_Out    (halted),
        .MICRO_SEQUENCER_Error_Out     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req"},    32'(mem_req), 32'd0);
        check({tag, "_stall"},  32'(stall),   32'd0);
        check({tag, "_halted"}, 32'(halted),  32'd0);
        check({tag, "_err"},    32'(err),     32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_access = 1'b0; mem_ack = 1'b0; halt = 1'b0; psr_load = 1'b0; tipo = 2'b00;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #3;
        check("rst_cs", 32'(cs_addr), 32'd0);
        check("rst_psr", 32'(psr), 32'd0);
        check_idle_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential advance
        for (int i = 1; i <= 5; i++) begin
            step();
            check("seq_cs", 32'(cs_addr), 32'(i));
            check_idle_outputs("seq");
        end

        // Wrap from 2047
        tipo = 2'b01; jump_addr = 11'd2047;
        step();
        check("jmp2047_cs", 32'(cs_addr), 32'd2047);
        tipo = 2'b00;
        step();
        check("wrap_cs", 32'(cs_addr), 32'd0);

        tipo = 2'b01; jump_addr = 11'h5A3;
        step();
        check("jump_cs", 32'(cs_addr), 32'h5A3);
        // {1, op=10, op3=010000, 00} = 110_0100_0000
        tipo = 2'b10; ir_op = 8'b10_010000;
        step();
        check("decode_cs", 32'(cs_addr), 32'h640);

        // PSR load in RUN
        tipo = 2'b00; psr_load = 1'b1; alu_flags = 4'b1010;
        step();
        check("psr_load", 32'(psr), 32'hA);
        check("psr_load_cs", 32'(cs_addr), 32'h641);

        // Memory access acked in the third MEMWAIT cycle
        tipo = 2'b01; jump_addr = 11'h100; mem_access = 1'b1; alu_flags = 4'b1111;
        #1 check("mem_run_stall", 32'(stall), 32'd1);
        step();
        mem_access = 1'b0;
        check("mem_w1_req", 32'(mem_req), 32'd1);
        check("mem_w1_stall", 32'(stall), 32'd1);
        check("mem_w1_cs", 32'(cs_addr), 32'h641);
        check("mem_run_psr_held", 32'(psr), 32'hA);
        step();
        check("mem_w2_req", 32'(mem_req), 32'd1);
        check("mem_w2_stall", 32'(stall), 32'd1);
        check("mem_w1_psr_held", 32'(psr), 32'hA);
        step();
        mem_ack = 1'b1; alu_flags = 4'b0110;
        #1;
        check("mem_w3_req", 32'(mem_req), 32'd1);
        check("mem_w3_stall", 32'(stall), 32'd0);
        check("mem_w3_psr_held", 32'(psr), 32'hA);
        step();
        mem_ack = 1'b0; psr_load = 1'b0;
        check("mem_done_cs", 32'(cs_addr), 32'h100);
        check("mem_done_psr", 32'(psr), 32'h6);
        check_idle_outputs("mem_done");

        // Ack in the 16th MEMWAIT cycle still returns to RUN
        tipo = 2'b00; mem_access = 1'b1;
        step();
        mem_access = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("late_ack_req", 32'(mem_req), 32'd1);
        check("late_ack_halted", 32'(halted), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("late_ack_cs", 32'(cs_addr), 32'h101);
        check_idle_outputs("late_ack");

        // Timeout after 16 MEMWAIT cycles
        tipo = 2'b01; jump_addr = 11'h123; mem_access = 1'b1;
        step();
        mem_access = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("to_pre_halted", 32'(halted), 32'd0);
        check("to_pre_err", 32'(err), 32'd0);
        step();
        check("to_halted", 32'(halted), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_req", 32'(mem_req), 32'd0);
        check("to_stall", 32'(stall), 32'd1);
        check("to_cs", 32'(cs_addr), 32'h101);
        tipo = 2'b00; psr_load = 1'b1; alu_flags = 4'b0001; mem_ack = 1'b1;
        step();
        step();
        check("halt_cs_frozen", 32'(cs_addr), 32'h101);
        check("halt_psr_frozen", 32'(psr), 32'h6);
        check("halt_still", 32'(halted), 32'd1);
        psr_load = 1'b0; mem_ack = 1'b0;

        do_reset();
        check("rst2_cs", 32'(cs_addr), 32'd0);
        check("rst2_psr", 32'(psr), 32'd0);
        check_idle_outputs("rst2");

        // Halt wins over MemAccess
        halt = 1'b1; mem_access = 1'b1;
        step();
        halt = 1'b0; mem_access = 1'b0;
        check("hm_halted", 32'(halted), 32'd1);
        check("hm_req", 32'(mem_req), 32'd0);
        check("hm_cs", 32'(cs_addr), 32'd0);
        check("hm_err", 32'(err), 32'd0);

        do_reset();
        // Reset mid-MEMWAIT is asynchronous; a trailing ack is ignored
        tipo = 2'b01; jump_addr = 11'h055;
        step();
        mem_access = 1'b1;
        step();
        mem_access = 1'b0;
        check("mw_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", 32'(mem_req), 32'd0);
        check("async_cs", 32'(cs_addr), 32'd0);
        check("async_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tipo = 2'b00; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("post_rst_cs", 32'(cs_addr), 32'd1);
        check_idle_outputs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
